nor_chain_pulse_gen: RTL and testbench
======================================

Name: nor_chain_pulse_gen

Overview:
- Upstream stimulus stage for the NOR/inverter delay chains; its output drives the chain input pin (myin).
- Generates a programmable train of N digital pulses with programmed width and gap, measured in clock cycles.
- The chain response to short pulses (glitch degradation and cancellation) is then characterised.
- Fully synchronous FSM with a registered, glitch-free output.

Parameters:
- CNT_W, 16, width of the pulse-width, gap and step counters/operands.
- NUM_W, 8, width of the pulse-count operand and counter.

Ports:
- myclk  input  1  clock, rising edge.
- myrst_n  input  1  asynchronous active-low reset.
- mystart  input  1  start request; sampled only in IDLE.
- myabort  input  1  synchronous abort; returns to IDLE.
- mywidth  input  CNT_W  pulse width in cycles; 0 is treated as 1.
- mygap  input  CNT_W  inter-pulse gap in cycles; 0 is treated as 1.
- mynum  input  NUM_W  number of pulses; 0 means no pulse.
- myinit_level  input  1  idle (rest) level of myout; the pulse level is its inverse.
- mystep  input  CNT_W  per-pulse width decrement; used only with the optional feature.
- myout  output  1  registered stimulus to the chain input.
- mybusy  output  1  high while a train is in progress.
- mydone  output  1  one-cycle completion strobe.

Behaviour:
- Reset (async assert, sync release): all outputs are 0, state is IDLE, all counters are 0.
- States:
  - IDLE, PULSE, GAP, FIN.
  - Operands mywidth, mygap, mynum, myinit_level and mystep are latched on the accepted start edge.
  - Operand changes mid-train are ignored.
- IDLE:
  - myout <= myinit_level every cycle.
  - mybusy = 0.
  - mystart = 1 with mynum != 0 -> PULSE; myout is at the pulse level from the next edge.
  - mystart = 1 with mynum == 0 -> FIN directly; no pulse is emitted.
- PULSE:
  - myout is held at the pulse level for exactly W = max(mywidth, 1) cycles.
  - Pulse counter decrements at the end of the pulse.
  - Remaining pulses > 0 -> GAP; otherwise -> FIN.
- GAP:
  - myout is at the rest level for exactly G = max(mygap, 1) cycles, then -> PULSE.
- FIN:
  - One cycle; myout is at the rest level and mydone = 1.
  - mybusy = 0 in FIN.
  - Next state is IDLE.
- mybusy is 1 in PULSE and GAP only.
- Latency: start accepted at edge k -> first pulse-level cycle begins at edge k+1.
- Train length from first pulse edge to FIN is N*W + (N-1)*G cycles.
- mystart while busy or in FIN is ignored; it is not queued.
- myabort = 1 in any state -> IDLE at the next edge:
  - myout returns to the rest level.
  - No mydone is issued.
  - myabort has priority over mystart in the same cycle.
- Counter arithmetic:
  - Counters count down from the loaded value to 1 with no wrap.
  - Maximum values (2^CNT_W - 1, 2^NUM_W - 1) must work exactly.
- Reset asserted mid-train: myout, mybusy and mydone go to 0 immediately (asynchronously).
- Glitch-free output: myout comes directly from a flop, never from combinational decode.

Optional Feature:
- Macro: NOR_CHAIN_PULSE_SWEEP_EN.
- Defined:
  - After each completed pulse, the latched width becomes max(W - mystep, 1), computed with saturation.
  - This produces a shrinking-pulse sweep within one train.
  - mystep == 0 gives a constant width.
- Undefined:
  - mystep is ignored (the port still exists) and all pulses have width W.
  - No subtractor is synthesised.

Test Plan:
- Reset then idle: myrst_n low, then high, myinit_level = 0 -> myout = 0, mybusy = 0, mydone = 0; with myinit_level = 1, myout = 1 one cycle later.
- Basic train: width = 3, gap = 2, num = 4, init = 0, start at edge k.
  - myout = 1 in cycles k+1..k+3, 0 in k+4..k+5, repeating.
  - The last high cycle is k+18.
  - mydone pulses once in cycle k+19; mybusy is high k+1..k+18.
- Zero operands and inverted level: width = 0, gap = 0, num = 2, init = 1 -> pattern 0,1,0 (1-cycle pulses and gap), then mydone; num = 0 -> mydone at k+1 with no pulse.
- Abort and ignore: myabort mid-gap -> myout at the rest level, IDLE next cycle, no mydone; mystart pulsed while busy -> no effect on the train count.
- Async reset mid-pulse: drop myrst_n during PULSE -> myout = 0 immediately; after release the block is in IDLE and a new start works.
- Sweep (macro defined): width = 5, step = 2, num = 4, gap = 1 -> pulse widths 5, 3, 1, 1. With the macro undefined, the same stimulus gives widths 5, 5, 5, 5.

Source files
------------

// File: rtl/nor_chain_pulse_gen_if.sv
// Control/status bundle for nor_chain_pulse_gen: start/abort handshake,
// train operands and the registered stimulus/status outputs.
interface nor_chain_pulse_gen_if #(
  parameter int CNT_W = 16,
  parameter int NUM_W = 8
);
  logic             mystart;
  logic             myabort;
  logic [CNT_W-1:0] mywidth;
  logic [CNT_W-1:0] mygap;
  logic [NUM_W-1:0] mynum;
  logic             myinit_level;
  logic [CNT_W-1:0] mystep;
  logic             myout;
  logic             mybusy;
  logic             mydone;

  modport master (
    output mystart, myabort, mywidth, mygap, mynum, myinit_level, mystep,
    input  myout, mybusy, mydone
  );

  modport slave (
    input  mystart, myabort, mywidth, mygap, mynum, myinit_level, mystep,
    output myout, mybusy, mydone
  );
endinterface

// File: rtl/nor_chain_pulse_gen.sv
// Programmable pulse-train generator driving the NOR/inverter chain input.
// Define NOR_CHAIN_PULSE_SWEEP_EN to shrink the width by mystep after each pulse.
module nor_chain_pulse_gen #(
  parameter int CNT_W = 16,
  parameter int NUM_W = 8
) (
  input  logic                  myclk,
  input  logic                  myrst_n,
  nor_chain_pulse_gen_if.slave  bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PULSE = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;
  localparam logic [1:0] ST_FIN   = 2'd3;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] w_lat;
  logic [CNT_W-1:0] g_lat;
  logic [NUM_W-1:0] n_left;
  logic             rest_lvl;
  logic             out_q;
  logic             busy_q;
  logic             done_q;

  logic [CNT_W-1:0] w_start;
  logic [CNT_W-1:0] g_start;
  logic [CNT_W-1:0] w_next;

  always_comb begin
    w_start = (bus.mywidth == '0) ? CNT_W'(1) : bus.mywidth;
    g_start = (bus.mygap   == '0) ? CNT_W'(1) : bus.mygap;
  end

`ifdef NOR_CHAIN_PULSE_SWEEP_EN
  logic [CNT_W-1:0] step_lat;

  // Saturate at one cycle so a pulse never disappears from the train.
  always_comb begin
    w_next = (w_lat > step_lat) ? (w_lat - step_lat) : CNT_W'(1);
  end
`else
  logic unused_step;

  assign unused_step = ^bus.mystep;

  always_comb begin
    w_next = w_lat;
  end
`endif

  always_ff @(posedge myclk or negedge myrst_n) begin
    if (!myrst_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      w_lat    <= '0;
      g_lat    <= '0;
      n_left   <= '0;
      rest_lvl <= 1'b0;
      out_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef NOR_CHAIN_PULSE_SWEEP_EN
      step_lat <= '0;
`endif
    end else if (bus.myabort) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      n_left <= '0;
      out_q  <= (state == ST_IDLE) ? bus.myinit_level : rest_lvl;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          out_q  <= bus.myinit_level;
          busy_q <= 1'b0;
          done_q <= 1'b0;
          if (bus.mystart) begin
            w_lat    <= w_start;
            g_lat    <= g_start;
            rest_lvl <= bus.myinit_level;
`ifdef NOR_CHAIN_PULSE_SWEEP_EN
            step_lat <= bus.mystep;
`endif
            if (bus.mynum != '0) begin
              state  <= ST_PULSE;
              cnt    <= w_start;
              n_left <= bus.mynum;
              out_q  <= ~bus.myinit_level;
              busy_q <= 1'b1;
            end else begin
              state  <= ST_FIN;
              done_q <= 1'b1;
            end
          end
        end

        ST_PULSE: begin
          if (cnt == CNT_W'(1)) begin
            w_lat <= w_next;
            out_q <= rest_lvl;
            if (n_left == NUM_W'(1)) begin
              state  <= ST_FIN;
              cnt    <= '0;
              n_left <= '0;
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end else begin
              state  <= ST_GAP;
              cnt    <= g_lat;
              n_left <= n_left - NUM_W'(1);
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        ST_GAP: begin
          if (cnt == CNT_W'(1)) begin
            state <= ST_PULSE;
            cnt   <= w_lat;
            out_q <= ~rest_lvl;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        default: begin
          state  <= ST_IDLE;
          out_q  <= rest_lvl;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.myout  = out_q;
  assign bus.mybusy = busy_q;
  assign bus.mydone = done_q;

endmodule

// File: tb/tb_nor_chain_pulse_gen.sv
// Directed self-checking bench for nor_chain_pulse_gen; expected waveforms
// are hand-written per-cycle patterns of myout.
module tb_nor_chain_pulse_gen;
  localparam int CNT_W = 16;
  localparam int NUM_W = 8;

  logic myclk   = 1'b0;
  logic myrst_n = 1'b0;

  always #5 myclk = ~myclk;

  nor_chain_pulse_gen_if #(.CNT_W(CNT_W), .NUM_W(NUM_W)) bus_if ();

  nor_chain_pulse_gen #(.CNT_W(CNT_W), .NUM_W(NUM_W)) dut (
    .myclk   (myclk),
    .myrst_n (myrst_n),
    .bus     (bus_if)
  );

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge myclk);
    #1;
  endtask

  task automatic start(input int unsigned w, input int unsigned g, input int unsigned n,
                       input logic init, input int unsigned step);
    bus_if.mywidth      = CNT_W'(w);
    bus_if.mygap        = CNT_W'(g);
    bus_if.mynum        = NUM_W'(n);
    bus_if.myinit_level = init;
    bus_if.mystep       = CNT_W'(step);
    bus_if.mystart      = 1'b1;
    tick();
    bus_if.mystart      = 1'b0;
  endtask

  // pat gives myout for each cycle from the first pulse edge; FIN follows.
  task automatic expect_train(input string tag, input string pat, input logic rest);
    for (int i = 0; i < pat.len(); i++) begin
      check({tag, "_out"},  {31'd0, bus_if.myout},  (pat.getc(i) == "1") ? 32'd1 : 32'd0);
      check({tag, "_busy"}, {31'd0, bus_if.mybusy}, 32'd1);
      check({tag, "_done"}, {31'd0, bus_if.mydone}, 32'd0);
      tick();
    end
    check({tag, "_fin_done"}, {31'd0, bus_if.mydone}, 32'd1);
    check({tag, "_fin_busy"}, {31'd0, bus_if.mybusy}, 32'd0);
    check({tag, "_fin_out"},  {31'd0, bus_if.myout},  {31'd0, rest});
    tick();
    check({tag, "_done_once"}, {31'd0, bus_if.mydone}, 32'd0);
  endtask

  initial begin
    bus_if.mystart      = 1'b0;
    bus_if.myabort      = 1'b0;
    bus_if.mywidth      = '0;
    bus_if.mygap        = '0;
    bus_if.mynum        = '0;
    bus_if.myinit_level = 1'b0;
    bus_if.mystep       = '0;

    // Reset and idle level tracking
    #12;
    check("rst_out",  {31'd0, bus_if.myout},  32'd0);
    check("rst_busy", {31'd0, bus_if.mybusy}, 32'd0);
    check("rst_done", {31'd0, bus_if.mydone}, 32'd0);
    bus_if.myinit_level = 1'b1;
    #10;
    check("rst_hold_out", {31'd0, bus_if.myout}, 32'd0);
    bus_if.myinit_level = 1'b0;
    myrst_n = 1'b1;
    tick();
    check("idle_out",  {31'd0, bus_if.myout},  32'd0);
    check("idle_busy", {31'd0, bus_if.mybusy}, 32'd0);
    check("idle_done", {31'd0, bus_if.mydone}, 32'd0);
    bus_if.myinit_level = 1'b1;
    tick();
    check("idle_lvl1", {31'd0, bus_if.myout}, 32'd1);
    bus_if.myinit_level = 1'b0;
    tick();
    check("idle_lvl0", {31'd0, bus_if.myout}, 32'd0);

    // Basic train; operands scrambled mid-train must be ignored
    start(3, 2, 4, 1'b0, 0);
    bus_if.mywidth      = 16'd9;
    bus_if.mygap        = 16'd9;
    bus_if.mynum        = 8'd1;
    bus_if.myinit_level = 1'b1;
    expect_train("basic", "111001110011100111", 1'b0);
    bus_if.myinit_level = 1'b0;
    tick();

    // Zero width/gap with inverted rest level
    start(0, 0, 2, 1'b1, 0);
    expect_train("zero", "010", 1'b1);
    bus_if.myinit_level = 1'b0;
    tick();

    // Zero pulse count: straight to FIN
    start(4, 4, 0, 1'b0, 0);
    check("num0_done", {31'd0, bus_if.mydone}, 32'd1);
    check("num0_busy", {31'd0, bus_if.mybusy}, 32'd0);
    check("num0_out",  {31'd0, bus_if.myout},  32'd0);
    tick();
    check("num0_done_once", {31'd0, bus_if.mydone}, 32'd0);

    // Abort mid-gap
    start(3, 4, 3, 1'b0, 0);
    for (int i = 0; i < 3; i++) begin
      check("abort_pulse", {31'd0, bus_if.myout}, 32'd1);
      tick();
    end
    check("abort_gap_out",  {31'd0, bus_if.myout},  32'd0);
    check("abort_gap_busy", {31'd0, bus_if.mybusy}, 32'd1);
    tick();
    bus_if.myabort = 1'b1;
    tick();
    bus_if.myabort = 1'b0;
    check("abort_out",  {31'd0, bus_if.myout},  32'd0);
    check("abort_busy", {31'd0, bus_if.mybusy}, 32'd0);
    check("abort_done", {31'd0, bus_if.mydone}, 32'd0);
    tick();
    check("abort_nodone", {31'd0, bus_if.mydone}, 32'd0);
    check("abort_idle",   {31'd0, bus_if.mybusy}, 32'd0);

    // Abort wins over a simultaneous start
    bus_if.mynum   = 8'd2;
    bus_if.mywidth = 16'd2;
    bus_if.mystart = 1'b1;
    bus_if.myabort = 1'b1;
    tick();
    bus_if.mystart = 1'b0;
    bus_if.myabort = 1'b0;
    check("abort_prio_busy", {31'd0, bus_if.mybusy}, 32'd0);
    check("abort_prio_out",  {31'd0, bus_if.myout},  32'd0);
    tick();
    check("abort_prio_idle", {31'd0, bus_if.mybusy}, 32'd0);

    // Start held high while busy and in FIN is not queued
    start(2, 1, 2, 1'b0, 0);
    bus_if.mystart = 1'b1;
    expect_train("busy_start", "11011", 1'b0);
    bus_if.mystart = 1'b0;
    tick();
    check("busy_start_noq", {31'd0, bus_if.mybusy}, 32'd0);

    // Asynchronous reset mid-pulse, then restart
    start(10, 1, 1, 1'b0, 0);
    tick();
    check("arst_pre_out", {31'd0, bus_if.myout}, 32'd1);
    #2;
    myrst_n = 1'b0;
    #1;
    check("arst_out",  {31'd0, bus_if.myout},  32'd0);
    check("arst_busy", {31'd0, bus_if.mybusy}, 32'd0);
    check("arst_done", {31'd0, bus_if.mydone}, 32'd0);
    #2;
    myrst_n = 1'b1;
    tick();
    check("arst_idle_out",  {31'd0, bus_if.myout},  32'd0);
    check("arst_idle_busy", {31'd0, bus_if.mybusy}, 32'd0);
    start(1, 1, 1, 1'b0, 0);
    expect_train("arst_restart", "1", 1'b0);

    // Maximum pulse count: 255 one-cycle pulses with one-cycle gaps
    start(1, 1, 255, 1'b0, 0);
    for (int i = 0; i < 509; i++) begin
      check("maxnum_out", {31'd0, bus_if.myout}, (i % 2 == 0) ? 32'd1 : 32'd0);
      tick();
    end
    check("maxnum_done", {31'd0, bus_if.mydone}, 32'd1);
    tick();

    // Width sweep
    start(5, 1, 4, 1'b0, 2);
`ifdef NOR_CHAIN_PULSE_SWEEP_EN
    expect_train("sweep", "1111101110101", 1'b0);
`else
    expect_train("sweep", "11111011111011111011111", 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
